// File: rtl/tff_mod_counter_if.sv
// tff_mod_counter_if: control/status bundle between a counter and its driver
interface tff_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic en;
  logic up;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic clr;
  logic [WIDTH-1:0] q;
  logic tc;
  logic ovf;
  modport master(output en, up, load, load_val, clr, input q, tc, ovf);
  modport slave(input en, up, load, load_val, clr, output q, tc, ovf);
endinterface

// File: rtl/tff_mod_counter.sv
// tff_mod_counter: modulo-N up/down counter with a toggle-style carry chain
module tff_mod_counter #(
  parameter int WIDTH = 4,
  parameter longint MODULUS = 16,
  parameter longint RESET_VALUE = 0
) (
  input logic clk,
  input logic reset,
  tff_mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT = WIDTH'(RESET_VALUE);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tff_mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("tff_mod_counter: MODULUS must be 2..2^WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
    $error("tff_mod_counter: RESET_VALUE must be below MODULUS");
  end
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] nxt;
  logic term;
  // a bit flips when all lower bits are ones (up) or zeros (down); the terminal value wraps instead
  always_comb begin
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) t[i] = t[i-1] & (bus.up ? bus.q[i-1] : ~bus.q[i-1]);
    term = bus.up ? bus.q == MAX : bus.q == '0;
    nxt = term ? (bus.up ? '0 : MAX) : bus.q ^ t;
  end
  assign bus.tc = !reset & bus.en & term;
  // falling-edge state update: reset > clr > load > en > hold
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      bus.q <= INIT;
      bus.ovf <= 1'b0;
    end else if (bus.clr) begin
      bus.q <= '0;
      bus.ovf <= 1'b0;
    end else if (bus.load) begin
      bus.q <= bus.load_val > MAX ? MAX : bus.load_val;
    end else if (bus.en) begin
      bus.q <= nxt;
      if (term) bus.ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter: scoreboard bench for the modulo-10 counter and a two-stage cascade
module tb_tff_mod_counter;
  typedef struct {
    string nm;
    logic sel;
    logic [3:0] q;
    logic tc;
    logic ovf;
  } exp_t;
  logic clk = 1'b1;
  logic reset = 1'b1;
  logic creset = 1'b1;
  logic probe = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  tff_mod_counter_if #(.WIDTH(4)) b1 ();
  tff_mod_counter_if #(.WIDTH(4)) b2 ();
  tff_mod_counter_if #(.WIDTH(4)) b3 ();
  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut (.clk(clk), .reset(reset), .bus(b1));
  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) st1 (.clk(clk), .reset(creset), .bus(b2));
  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) st2 (.clk(clk), .reset(creset), .bus(b3));
  assign b3.en = b2.tc;
  always #5 clk = ~clk;
  task automatic push(input string nm, input logic sel, input logic [3:0] eq, input logic et, input logic eo);
    exp_t e;
    e.nm = nm;
    e.sel = sel;
    e.q = eq;
    e.tc = et;
    e.ovf = eo;
    sb.push_back(e);
  endtask
  task automatic peek(input string nm, input logic [3:0] eq, input logic et, input logic eo);
    push(nm, 1'b0, eq, et, eo);
    probe = 1'b1;
    #1 probe = 1'b0;
  endtask
  task automatic step(input string nm, input logic e, input logic u, input logic l, input logic [3:0] lv,
                      input logic c, input logic [3:0] eq, input logic et, input logic eo);
    b1.en = e;
    b1.up = u;
    b1.load = l;
    b1.load_val = lv;
    b1.clr = c;
    @(negedge clk);
    push(nm, 1'b0, eq, et, eo);
    @(posedge clk);
    #2;
  endtask
  initial forever begin
    exp_t e;
    logic [3:0] aq;
    logic at;
    logic ao;
    @(posedge clk or posedge probe);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      aq = e.sel ? b3.q : b1.q;
      at = e.sel ? b3.tc : b1.tc;
      ao = e.sel ? b3.ovf : b1.ovf;
      tests++;
      if (aq !== e.q || at !== e.tc || ao !== e.ovf) begin
        fails++;
        $display("FAIL %s: got q=%0d tc=%0b ovf=%0b, expected q=%0d tc=%0b ovf=%0b",
                 e.nm, aq, at, ao, e.q, e.tc, e.ovf);
      end
    end
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    b1.en = 1'b0;
    b1.up = 1'b0;
    b1.load = 1'b0;
    b1.load_val = 4'd0;
    b1.clr = 1'b0;
    b2.en = 1'b1;
    b2.up = 1'b1;
    b2.load = 1'b0;
    b2.load_val = 4'd0;
    b2.clr = 1'b0;
    b3.up = 1'b1;
    b3.load = 1'b0;
    b3.load_val = 4'd0;
    b3.clr = 1'b0;
    #3 peek("reset", 4'd0, 1'b0, 1'b0);
    #4 reset = 1'b0;
    for (int i = 1; i <= 9; i++) step($sformatf("up_%0d", i), 1, 1, 0, 0, 0, 4'(i), i == 9, 0);
    step("up_wrap", 1, 1, 0, 0, 0, 4'd0, 0, 1);
    step("clear", 0, 1, 0, 0, 1, 4'd0, 0, 0);
    b1.en = 1'b1;
    b1.up = 1'b0;
    b1.clr = 1'b0;
    peek("down_tc_before_wrap", 4'd0, 1'b1, 1'b0);
    step("down_wrap", 1, 0, 0, 0, 0, 4'd9, 0, 1);
    step("down_8", 1, 0, 0, 0, 0, 4'd8, 0, 1);
    step("down_7", 1, 0, 0, 0, 0, 4'd7, 0, 1);
    step("load_7_en", 1, 0, 1, 4'd7, 0, 4'd7, 0, 1);
    step("load_12_clamp", 1, 1, 1, 4'd12, 0, 4'd9, 1, 1);
    step("load_5", 0, 1, 1, 4'd5, 0, 4'd5, 0, 1);
    step("clr_over_load", 1, 1, 1, 4'd3, 1, 4'd0, 0, 0);
    step("load_6", 0, 1, 1, 4'd6, 0, 4'd6, 0, 0);
    b1.en = 1'b1;
    b1.up = 1'b1;
    b1.load = 1'b0;
    peek("pre_reset", 4'd6, 1'b0, 1'b0);
    reset = 1'b1;
    #1 peek("async_reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    push("reset_held", 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    push("resume_1", 1'b0, 4'd1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    step("load_9", 0, 1, 1, 4'd9, 0, 4'd9, 0, 0);
    for (int i = 0; i < 5; i++) step($sformatf("hold_%0d", i), 0, i[0], 0, 0, 0, 4'd9, 0, 0);
    b1.en = 1'b0;
    creset = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      push($sformatf("cascade_%0d", n), 1'b1, 4'(n / 10), 1'b0, 1'b0);
      @(posedge clk);
      #2;
    end
    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
- Parametrised synchronous modulo-N up/down counter built in the toggle-flip-flop style: each bit toggles when all lower-order conditions allow it.
- Adds count enable, direction control, parallel load, synchronous clear, a cascade terminal-count output and a sticky wrap flag.
- Used as the general counter/prescaler primitive for timing, dividers and cascaded multi-digit counters.
- State updates on the falling edge of clk, matching the rest of the flip-flop family in this codebase.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH; elaboration error if out of range.
- RESET_VALUE, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  input  1  counter clock; state changes on negedge.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  count enable; sampled at negedge clk.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- clr  input  1  synchronous clear of q and ovf.
- q  output  WIDTH  registered count value.
- tc  output  1  terminal count, combinational, for cascading.
- ovf  output  1  sticky wrap flag, registered.

Behaviour:
- Reset (async, active-high):
  - q = RESET_VALUE and ovf = 0 immediately on the rising edge of reset; no clock edge is needed.
  - Both are held for as long as reset = 1.
  - tc follows its equation, so it is 0 while reset = 1 because q = RESET_VALUE and en is qualified by !reset.
- Per-negedge priority, highest first: reset > clr > load > en > hold.
- clr = 1: q <= 0, ovf <= 0, regardless of load or en.
- load = 1 (clr = 0):
  - q <= load_val if load_val < MODULUS, otherwise q <= MODULUS-1 (clamp).
  - ovf is unchanged; en is ignored that cycle.
- en = 1, up = 1: q <= (q == MODULUS-1) ? 0 : q+1; on that wrap, ovf <= 1.
- en = 1, up = 0: q <= (q == 0) ? MODULUS-1 : q-1; on that wrap, ovf <= 1.
- en = 0: q and ovf hold; up changes have no effect.
- tc = !reset & en & ((up & q == MODULUS-1) | (!up & q == 0)).
  - Combinational, so it is asserted in the half-cycle before the wrapping edge.
  - A downstream stage wires its en to the upstream tc, with the same clk.
- When MODULUS == 2^WIDTH, arithmetic wraps naturally and behaviour is identical to the rules above.
- ovf stays 1 until clr or reset; further wraps keep it at 1.
- Reset asserted mid-cycle, including between a load setup and its edge: the pending load is discarded. After reset deasserts, the next negedge applies the normal priority.
- No X propagation: q is always a defined value after reset.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10, RESET_VALUE=0 and clk period 10 (negedges at 5, 15, 25, …).

1. Reset then count up:
   - reset=1 for 0..7 -> q=0, ovf=0, tc=0.
   - en=1, up=1 from 7 -> q runs 1,2,…,9 on successive negedges.
   - tc=1 only while q=9; the next negedge gives q=0 and ovf=1.
2. Count down with wrap:
   - From q=0 with en=1, up=0 -> tc=1 immediately.
   - Next negedge gives q=9 and ovf=1; then 8, 7 and so on.
3. Load and clamp:
   - load=1, load_val=7, en=1 -> q=7 after the next negedge, not 8.
   - load_val=12 -> q=9.
   - ovf is unchanged in both cases.
4. Clear vs load conflict:
   - With ovf=1 and q=5, set clr=1, load=1, load_val=3 at the same negedge -> q=0, ovf=0.
5. Async reset mid-operation:
   - With q=6 and en=1, raise reset at t=22 (between edges) -> q=0 by t=22.
   - Hold reset to t=33, release -> counting resumes: q=1 at the negedge at 35.
6. Hold and cascade:
   - en=0 while toggling up for 5 cycles -> q constant, tc=0.
   - Two instances cascaded (stage 2 en = stage 1 tc), counting up from 0 -> stage 2 increments exactly once per 10 negedges, i.e. after the 10th, 20th, … edges.
